lut_sequencer: RTL and testbench

Table-driven pattern sequencer downstream of the serial table loader. When the loader raises its finished flag, the block snapshots the five 5-bit table entries and the 2-bit rate select, then plays the entries out cyclically on `state_out`. One entry is held for a programmable number of cycles. The block drives the design's output pins and supplies a step strobe to the status logic.

---
 rtl/lut_seq_pkg.sv | 30 +++
 rtl/lut_seq_prescaler.sv | 37 +++
 rtl/lut_sequencer.sv | 169 ++++++++++++++++
 tb/tb_lut_sequencer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/lut_seq_pkg.sv
// Shared types and constants for the table-driven pattern sequencer.
package lut_seq_pkg;

  localparam int W       = 5;
  localparam int ENTRIES = 5;
  localparam int PRE_W   = 6;

  // Entry value treated as end-of-sequence when LUT_SEQ_STOP_CODE_EN is defined.
  localparam logic [W-1:0] STOP_CODE = 5'h1F;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2,
    ST_EMPTY = 2'd3
  } state_e;

  // Maps the step-rate select to the prescaler terminal count (D-1).
  function automatic logic [PRE_W-1:0] div_tc(input logic [1:0] sel);
    logic [PRE_W-1:0] tc;
    case (sel)
      2'b00:   tc = 6'd0;
      2'b01:   tc = 6'd3;
      2'b10:   tc = 6'd15;
      default: tc = 6'd63;
    endcase
    return tc;
  endfunction

endpackage

// File: rtl/lut_seq_prescaler.sv
// Step-rate prescaler: counts enabled cycles and ticks on the terminal count.
module lut_seq_prescaler
  import lut_seq_pkg::*;
(
  input  logic             clock,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [PRE_W-1:0] tc,
  output logic             tick
);

  logic [PRE_W-1:0] cnt_q, cnt_d;

  // The tick is the cycle in which the counter wraps back to zero.
  assign tick = en & ~clr & (cnt_q == tc);

  // Next count: clear wins, otherwise advance only while enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == tc) ? '0 : cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clock) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/lut_sequencer.sv
// Table-driven pattern sequencer: snapshots five entries when the loader
// finishes and plays them cyclically, one entry per D enabled cycles.
// Optional feature macro: LUT_SEQ_STOP_CODE_EN (entry 5'h1F ends the sequence).
module lut_sequencer
  import lut_seq_pkg::*;
(
  input  logic         clock,
  input  logic         rst,
  input  logic         load_done,
  input  logic [W-1:0] entry0,
  input  logic [W-1:0] entry1,
  input  logic [W-1:0] entry2,
  input  logic [W-1:0] entry3,
  input  logic [W-1:0] entry4,
  input  logic [1:0]   clk_sel,
  input  logic         en,
  output logic [W-1:0] state_out,
  output logic [2:0]   idx,
  output logic         running,
  output logic         step_pulse,
  output logic         wrap
);

  state_e       state_q, state_d;
  logic         ld_prev_q, ld_prev_d;
  logic         ld_rise_q, ld_rise_d;
  logic [W-1:0] tbl_q [ENTRIES];
  logic [W-1:0] tbl_d [ENTRIES];
  logic [1:0]   sel_q, sel_d;
  logic [2:0]   idx_q, idx_d;
  logic [W-1:0] state_out_q, state_out_d;
  logic         running_q, running_d;
  logic         step_pulse_q, step_pulse_d;
  logic         wrap_q, wrap_d;
  logic [2:0]   idx_nxt;

  logic pre_en;
  logic pre_clr;
  logic pre_tick;

  // Prescaler runs only in RUN with en high; anything else holds it at zero.
  assign pre_en  = (state_q == ST_RUN) & en;
  assign pre_clr = (state_q != ST_RUN) | ~load_done;

  lut_seq_prescaler u_prescaler (
    .clock (clock),
    .rst   (rst),
    .en    (pre_en),
    .clr   (pre_clr),
    .tc    (div_tc(sel_q)),
    .tick  (pre_tick)
  );

  // FSM next state, snapshot capture, index advance and registered outputs.
  always_comb begin
    ld_prev_d    = load_done;
    ld_rise_d    = load_done & ~ld_prev_q;
    state_d      = state_q;
    tbl_d        = tbl_q;
    sel_d        = sel_q;
    idx_d        = idx_q;
    state_out_d  = state_out_q;
    running_d    = running_q;
    step_pulse_d = 1'b0;
    wrap_d       = 1'b0;

    idx_nxt = (idx_q == 3'(ENTRIES - 1)) ? 3'd0 : idx_q + 3'd1;
`ifdef LUT_SEQ_STOP_CODE_EN
    if (tbl_q[idx_nxt] == STOP_CODE) begin
      idx_nxt = 3'd0;
    end
`endif

    case (state_q)
      ST_IDLE: begin
        idx_d       = '0;
        state_out_d = '0;
        running_d   = 1'b0;
        if (ld_rise_q) begin
          state_d = ST_LOAD;
        end
      end

      ST_LOAD: begin
        tbl_d[0] = entry0;
        tbl_d[1] = entry1;
        tbl_d[2] = entry2;
        tbl_d[3] = entry3;
        tbl_d[4] = entry4;
        sel_d    = clk_sel;
        idx_d    = '0;
        if (!load_done) begin
          state_d     = ST_IDLE;
          state_out_d = '0;
          running_d   = 1'b0;
`ifdef LUT_SEQ_STOP_CODE_EN
        end else if (entry0 == STOP_CODE) begin
          state_d     = ST_EMPTY;
          state_out_d = '0;
          running_d   = 1'b0;
`endif
        end else begin
          state_d     = ST_RUN;
          state_out_d = entry0;
          running_d   = 1'b1;
        end
      end

      ST_RUN: begin
        if (!load_done) begin
          state_d     = ST_IDLE;
          idx_d       = '0;
          state_out_d = '0;
          running_d   = 1'b0;
        end else if (pre_tick) begin
          idx_d        = idx_nxt;
          state_out_d  = tbl_q[idx_nxt];
          step_pulse_d = 1'b1;
          wrap_d       = (idx_nxt == 3'd0);
        end
      end

      default: begin
        idx_d       = '0;
        state_out_d = '0;
        running_d   = 1'b0;
        if (!load_done) begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  // State, snapshot and output registers; reset clears everything.
  always_ff @(posedge clock) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      ld_prev_q    <= 1'b0;
      ld_rise_q    <= 1'b0;
      sel_q        <= '0;
      idx_q        <= '0;
      state_out_q  <= '0;
      running_q    <= 1'b0;
      step_pulse_q <= 1'b0;
      wrap_q       <= 1'b0;
      for (int i = 0; i < ENTRIES; i++) begin
        tbl_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      ld_prev_q    <= ld_prev_d;
      ld_rise_q    <= ld_rise_d;
      sel_q        <= sel_d;
      idx_q        <= idx_d;
      state_out_q  <= state_out_d;
      running_q    <= running_d;
      step_pulse_q <= step_pulse_d;
      wrap_q       <= wrap_d;
      tbl_q        <= tbl_d;
    end
  end

  assign state_out  = state_out_q;
  assign idx        = idx_q;
  assign running    = running_q;
  assign step_pulse = step_pulse_q;
  assign wrap       = wrap_q;

endmodule

// File: tb/tb_lut_sequencer.sv
// Scoreboard bench for lut_sequencer: the driver queues the expected outputs
// for each upcoming edge, the monitor compares them on the falling edge.
module tb_lut_sequencer;

  logic       clock = 1'b0;
  logic       rst;
  logic       load_done;
  logic [4:0] entry0, entry1, entry2, entry3, entry4;
  logic [1:0] clk_sel;
  logic       en;
  logic [4:0] state_out;
  logic [2:0] idx;
  logic       running;
  logic       step_pulse;
  logic       wrap;

  lut_sequencer dut (
    .clock      (clock),
    .rst        (rst),
    .load_done  (load_done),
    .entry0     (entry0),
    .entry1     (entry1),
    .entry2     (entry2),
    .entry3     (entry3),
    .entry4     (entry4),
    .clk_sel    (clk_sel),
    .en         (en),
    .state_out  (state_out),
    .idx        (idx),
    .running    (running),
    .step_pulse (step_pulse),
    .wrap       (wrap)
  );

  always #5 clock = ~clock;

  typedef struct {
    int         cyc;
    logic [4:0] so;
    logic [2:0] ix;
    logic       r;
    logic       sp;
    logic       wr;
  } exp_t;

  exp_t q[$];
  int   cyc_cnt = 0;
  int   n_chk   = 0;
  int   n_fail  = 0;

  always @(posedge clock) cyc_cnt <= cyc_cnt + 1;

  // Monitor: pop every expectation due in this cycle and compare.
  always @(negedge clock) begin : mon
    exp_t e;
    while (q.size() > 0 && q[0].cyc <= cyc_cnt) begin
      e = q.pop_front();
      n_chk++;
      if (state_out !== e.so || idx !== e.ix || running !== e.r ||
          step_pulse !== e.sp || wrap !== e.wr) begin
        n_fail++;
        $display("FAIL outputs cyc=%0d: got state_out=%0d idx=%0d running=%0b step=%0b wrap=%0b, expected %0d %0d %0b %0b %0b",
                 cyc_cnt, state_out, idx, running, step_pulse, wrap, e.so, e.ix, e.r, e.sp, e.wr);
      end
    end
  end

  // Queue the outputs expected after the next edge, then take that edge.
  task automatic tick_exp(input logic [4:0] so, input logic [2:0] ix,
                          input logic r, input logic sp, input logic wr);
    exp_t e;
    e.cyc = cyc_cnt + 1;
    e.so  = so;
    e.ix  = ix;
    e.r   = r;
    e.sp  = sp;
    e.wr  = wr;
    q.push_back(e);
    @(posedge clock);
    #1;
  endtask

  task automatic tick_zero();
    tick_exp(5'd0, 3'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Expected playback: step s shows v[s % len] at index s % len for d cycles.
  task automatic play(input logic [4:0] v [5], input int len, input int d,
                      input int s_from, input int s_to);
    int k;
    for (int s = s_from; s < s_to; s++) begin
      k = s % len;
      for (int c = 0; c < d; c++) begin
        tick_exp(v[k], 3'(k), 1'b1, (c == 0) && (s > 0), (c == 0) && (s > 0) && (k == 0));
      end
    end
  endtask

  task automatic set_entries(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c,
                             input logic [4:0] d, input logic [4:0] e);
    entry0 = a;
    entry1 = b;
    entry2 = c;
    entry3 = d;
    entry4 = e;
  endtask

  // Raise load_done: two edges of zero output (edge detect, LOAD) before RUN.
  task automatic start_load();
    load_done = 1'b1;
    tick_zero();
    tick_zero();
  endtask

  initial begin : drv
    logic [4:0] v [5];

    rst       = 1'b1;
    load_done = 1'b0;
    en        = 1'b1;
    clk_sel   = 2'b00;
    set_entries(5'd0, 5'd0, 5'd0, 5'd0, 5'd0);
    @(posedge clock);
    #1;
    // Reset state.
    tick_zero();
    tick_zero();
    rst = 1'b0;
    tick_zero();

    // D = 1: entries 1..5, step every cycle, wrap every fifth.
    set_entries(5'd1, 5'd2, 5'd3, 5'd4, 5'd5);
    v = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5};
    start_load();
    play(v, 5, 1, 0, 12);
    load_done = 1'b0;
    tick_zero();

    // D = 16, with the entry inputs scrambled after the snapshot.
    clk_sel = 2'b10;
    set_entries(5'd3, 5'd6, 5'd9, 5'd12, 5'd15);
    v = '{5'd3, 5'd6, 5'd9, 5'd12, 5'd15};
    start_load();
    play(v, 5, 16, 0, 1);
    set_entries(5'd30, 5'd29, 5'd28, 5'd27, 5'd26);
    clk_sel = 2'b00;
    play(v, 5, 16, 1, 6);
    load_done = 1'b0;
    tick_zero();

    // D = 4 with a 7-cycle pause inside the first entry: held 11 cycles.
    clk_sel = 2'b01;
    set_entries(5'd20, 5'd21, 5'd22, 5'd23, 5'd24);
    v = '{5'd20, 5'd21, 5'd22, 5'd23, 5'd24};
    start_load();
    tick_exp(5'd20, 3'd0, 1'b1, 1'b0, 1'b0);
    tick_exp(5'd20, 3'd0, 1'b1, 1'b0, 1'b0);
    en = 1'b0;
    for (int i = 0; i < 7; i++) tick_exp(5'd20, 3'd0, 1'b1, 1'b0, 1'b0);
    en = 1'b1;
    tick_exp(5'd20, 3'd0, 1'b1, 1'b0, 1'b0);
    tick_exp(5'd20, 3'd0, 1'b1, 1'b0, 1'b0);
    play(v, 5, 4, 1, 7);

    // Reset mid-run, then release with load_done still high.
    rst = 1'b1;
    tick_zero();
    rst = 1'b0;
    tick_zero();
    tick_zero();
    play(v, 5, 4, 0, 3);
    load_done = 1'b0;
    tick_zero();

    // Stop-code entry in the middle of the table.
    clk_sel = 2'b00;
    set_entries(5'd7, 5'd9, 5'd31, 5'd3, 5'd3);
    start_load();
`ifdef LUT_SEQ_STOP_CODE_EN
    v = '{5'd7, 5'd9, 5'd0, 5'd0, 5'd0};
    play(v, 2, 1, 0, 7);
`else
    v = '{5'd7, 5'd9, 5'd31, 5'd3, 5'd3};
    play(v, 5, 1, 0, 7);
`endif
    load_done = 1'b0;
    tick_zero();

    // Stop-code entry in slot 0.
    set_entries(5'd31, 5'd9, 5'd31, 5'd3, 5'd3);
    start_load();
`ifdef LUT_SEQ_STOP_CODE_EN
    for (int i = 0; i < 4; i++) tick_zero();
`else
    v = '{5'd31, 5'd9, 5'd31, 5'd3, 5'd3};
    play(v, 5, 1, 0, 6);
`endif
    load_done = 1'b0;
    tick_zero();

    // D = 64.
    clk_sel = 2'b11;
    set_entries(5'd1, 5'd2, 5'd3, 5'd4, 5'd5);
    v = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5};
    start_load();
    play(v, 5, 64, 0, 2);
    load_done = 1'b0;
    tick_zero();

    repeat (3) begin
      @(posedge clock);
      #1;
    end
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
